fifo_gen2: RTL and testbench

FIFO_GEN2 -- requirements
Module: fifo_gen2

---
 rtl/fifo_gen2_if.sv | 33 +++
 rtl/fifo_gen2.sv | 107 ++++++++++
 tb/tb_fifo_gen2.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_gen2_if.sv
// FIFO handshake bundle: producer/consumer signals plus occupancy status.
interface fifo_gen2_if #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic                  wr_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CW-1:0]         count;

  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, count
  );
endinterface

// File: rtl/fifo_gen2.sv
// Synchronous FIFO, arbitrary depth, registered or first-word-fall-through read,
// with per-cycle status pulses and occupancy flags decoded from a registered count.
module fifo_gen2 #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 1,
  parameter int unsigned AE_THRESH  = 1,
  parameter int unsigned FWFT       = 0
) (
  input logic         clk,
  input logic         rst_n,
  fifo_gen2_if.slave  fifo_if
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ack_q, overflow_q, underflow_q;
  logic          full_c, empty_c, wr_accept_c, rd_accept_c;

  assign full_c      = (count_q == CW'(FIFO_DEPTH));
  assign empty_c     = (count_q == '0);
  assign wr_accept_c = fifo_if.wr_en && !full_c;
  assign rd_accept_c = fifo_if.rd_en && !empty_c;

  // Pointer wrap uses an explicit compare so non-power-of-two depths work.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept_c) begin
      wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_accept_c) begin
      rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    unique case ({wr_accept_c, rd_accept_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_accept_c;
      overflow_q  <= fifo_if.wr_en && !wr_accept_c;
      underflow_q <= fifo_if.rd_en && !rd_accept_c;
    end
  end

  // Storage is deliberately not reset; pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_accept_c) begin
      mem_q[wr_ptr_q] <= fifo_if.data_in;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_rd
      logic [FIFO_WIDTH-1:0] data_out_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_out_q <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_accept_c;
          if (rd_accept_c) begin
            data_out_q <= mem_q[rd_ptr_q];
          end
        end
      end

      assign fifo_if.data_out = data_out_q;
      assign fifo_if.rd_valid = rd_valid_q;
    end else begin : g_fwft
      // Head word is presented straight from storage; rd_en acts as pop.
      assign fifo_if.data_out = mem_q[rd_ptr_q];
      assign fifo_if.rd_valid = !empty_c;
    end
  endgenerate

  assign fifo_if.wr_ack      = wr_ack_q;
  assign fifo_if.overflow    = overflow_q;
  assign fifo_if.underflow   = underflow_q;
  assign fifo_if.full        = full_c;
  assign fifo_if.empty       = empty_c;
  assign fifo_if.almostfull  = (count_q >= CW'(AF_THRESH)) && !full_c;
  assign fifo_if.almostempty = (count_q <= CW'(AE_THRESH)) && !empty_c;
  assign fifo_if.count       = count_q;
endmodule

// File: tb/tb_fifo_gen2.sv
// Bench for fifo_gen2: default registered-read instance plus a depth-5 FWFT instance.
module tb_fifo_gen2;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_gen2_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) b0 ();
  fifo_gen2_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) b1 ();

  fifo_gen2 #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) u0 (
    .clk(clk), .rst_n(rst_n), .fifo_if(b0.slave));
  fifo_gen2 #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_THRESH(3), .AE_THRESH(2), .FWFT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .fifo_if(b1.slave));

  typedef logic [15:0] wq_t [$];

  typedef struct {
    bit we; bit re; logic [15:0] din;
    int cnt; bit ack; bit ovf; bit unf; bit rv; logic [15:0] dout;
    bit full; bit empty; bit af; bit ae;
  } vec_t;

  wq_t q0, q1;
  logic [15:0] ed0, ed1;
  bit ea0, eo0, eu0, ev0, ea1, eo1, eu1, ev1;
  int n_cmp = 0;
  int n_bad = 0;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: a word queue bounded by the depth.
  task automatic mstep(inout wq_t q, input int d, input bit fwft, input bit we, input bit re,
                       input logic [15:0] din, inout logic [15:0] dout,
                       output bit ack, output bit ovf, output bit unf, output bit rv);
    bit wa, ra;
    logic [15:0] h;
    h  = '0;
    wa = we && (q.size() < d);
    ra = re && (q.size() > 0);
    if (ra) h = q.pop_front();
    if (wa) q.push_back(din);
    ack = wa;
    ovf = we && !wa;
    unf = re && !ra;
    if (!fwft) begin
      rv = ra;
      if (ra) dout = h;
    end else begin
      rv = (q.size() > 0);
    end
  endtask

  task automatic check_all();
    int s0, s1;
    s0 = q0.size();
    s1 = q1.size();
    chk("cnt0",   32'(b0.count),       32'(s0));
    chk("full0",  32'(b0.full),        32'(s0 == 8));
    chk("empty0", 32'(b0.empty),       32'(s0 == 0));
    chk("af0",    32'(b0.almostfull),  32'(s0 >= 7 && s0 < 8));
    chk("ae0",    32'(b0.almostempty), 32'(s0 <= 1 && s0 > 0));
    chk("ack0",   32'(b0.wr_ack),      32'(ea0));
    chk("ovf0",   32'(b0.overflow),    32'(eo0));
    chk("unf0",   32'(b0.underflow),   32'(eu0));
    chk("rv0",    32'(b0.rd_valid),    32'(ev0));
    chk("dout0",  32'(b0.data_out),    32'(ed0));
    chk("cnt1",   32'(b1.count),       32'(s1));
    chk("full1",  32'(b1.full),        32'(s1 == 5));
    chk("empty1", 32'(b1.empty),       32'(s1 == 0));
    chk("af1",    32'(b1.almostfull),  32'(s1 >= 3 && s1 < 5));
    chk("ae1",    32'(b1.almostempty), 32'(s1 <= 2 && s1 > 0));
    chk("ack1",   32'(b1.wr_ack),      32'(ea1));
    chk("ovf1",   32'(b1.overflow),    32'(eo1));
    chk("unf1",   32'(b1.underflow),   32'(eu1));
    chk("rv1",    32'(b1.rd_valid),    32'(ev1));
    if (s1 > 0) chk("dout1", 32'(b1.data_out), 32'(q1[0]));
  endtask

  task automatic step(input bit w0, input bit r0, input logic [15:0] d0,
                      input bit w1, input bit r1, input logic [15:0] d1);
    b0.wr_en = w0; b0.rd_en = r0; b0.data_in = d0;
    b1.wr_en = w1; b1.rd_en = r1; b1.data_in = d1;
    @(posedge clk);
    mstep(q0, 8, 1'b0, w0, r0, d0, ed0, ea0, eo0, eu0, ev0);
    mstep(q1, 5, 1'b1, w1, r1, d1, ed1, ea1, eo1, eu1, ev1);
    #1;
    check_all();
  endtask

  task automatic model_clear();
    q0.delete(); q1.delete();
    ed0 = '0; ea0 = 0; eo0 = 0; eu0 = 0; ev0 = 0;
    ea1 = 0; eo1 = 0; eu1 = 0; ev1 = 0;
  endtask

  // Reset asserted between edges, held across one edge, released on the falling edge.
  task automatic reset_mid();
    b0.wr_en = 0; b0.rd_en = 0; b1.wr_en = 0; b1.rd_en = 0;
    #2 rst_n = 1'b0;
    #1 model_clear();
    check_all();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    b0.wr_en = 0; b0.rd_en = 0; b0.data_in = '0;
    b1.wr_en = 0; b1.rd_en = 0; b1.data_in = '0;
    rst_n = 1'b0;
    model_clear();

    for (int i = 1; i <= 8; i++)
      tv.push_back('{we:1, re:0, din:16'(i), cnt:i, ack:1, ovf:0, unf:0, rv:0, dout:16'h0,
                     full:(i == 8), empty:0, af:(i == 7), ae:(i == 1)});
    tv.push_back('{we:1, re:0, din:16'h9, cnt:8, ack:0, ovf:1, unf:0, rv:0, dout:16'h0,
                   full:1, empty:0, af:0, ae:0});
    for (int k = 1; k <= 8; k++)
      tv.push_back('{we:0, re:1, din:16'h0, cnt:8-k, ack:0, ovf:0, unf:0, rv:1, dout:16'(k),
                     full:0, empty:(k == 8), af:((8-k) == 7), ae:((8-k) == 1)});
    tv.push_back('{we:0, re:1, din:16'h0, cnt:0, ack:0, ovf:0, unf:1, rv:0, dout:16'h8,
                   full:0, empty:1, af:0, ae:0});
    tv.push_back('{we:1, re:1, din:16'hABCD, cnt:1, ack:1, ovf:0, unf:1, rv:0, dout:16'h8,
                   full:0, empty:0, af:0, ae:1});

    #2 check_all();
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[n]) begin
      step(tv[n].we, tv[n].re, tv[n].din, 1'b0, 1'b0, 16'h0);
      chk("tv_cnt",   32'(b0.count),       32'(tv[n].cnt));
      chk("tv_ack",   32'(b0.wr_ack),      32'(tv[n].ack));
      chk("tv_ovf",   32'(b0.overflow),    32'(tv[n].ovf));
      chk("tv_unf",   32'(b0.underflow),   32'(tv[n].unf));
      chk("tv_rv",    32'(b0.rd_valid),    32'(tv[n].rv));
      chk("tv_dout",  32'(b0.data_out),    32'(tv[n].dout));
      chk("tv_full",  32'(b0.full),        32'(tv[n].full));
      chk("tv_empty", 32'(b0.empty),       32'(tv[n].empty));
      chk("tv_af",    32'(b0.almostfull),  32'(tv[n].af));
      chk("tv_ae",    32'(b0.almostempty), 32'(tv[n].ae));
    end

    // Steady-state simultaneous read/write at count 4 across pointer wrap.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'(16'h100 + i), 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 16'(16'h200 + i), 1'b0, 1'b0, 16'h0);
      chk("rw_cnt", 32'(b0.count), 32'd4);
    end
    chk("rw_last_dout", 32'(b0.data_out), 32'h20F);

    // Full with both requests: read wins, write rejected.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(16'h300 + i), 1'b0, 1'b0, 16'h0);
    chk("full_before", 32'(b0.full), 32'd1);
    step(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0);
    chk("full_rw_cnt",  32'(b0.count),    32'd7);
    chk("full_rw_ovf",  32'(b0.overflow), 32'd1);
    chk("full_rw_dout", 32'(b0.data_out), 32'h210);

    // FWFT instance: fall-through latency, flags and wrap.
    reset_mid();
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h11);
    chk("fwft_dout", 32'(b1.data_out), 32'h11);
    chk("fwft_rv",   32'(b1.rd_valid), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'(16'h12 + i));
    chk("fwft_full", 32'(b1.full), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'(16'h20 + i));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0);
    chk("fwft_unf", 32'(b1.underflow), 32'd1);

    // Randomised traffic with phase-varying write/read bias.
    for (int ph = 0; ph < 4; ph++) begin
      int pw, pr;
      pw = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      pr = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
      for (int i = 0; i < 100; i++)
        step(($urandom % 100) < pw, ($urandom % 100) < pr, 16'($urandom),
             ($urandom % 100) < pw, ($urandom % 100) < pr, 16'($urandom));
    end

    // Mid-transfer reset discards contents and pending pulses.
    reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'(16'h40 + i), 1'b1, 1'b0, 16'(16'h50 + i));
    reset_mid();
    chk("rst_cnt0",   32'(b0.count),  32'd0);
    chk("rst_empty1", 32'(b1.empty),  32'd1);
    step(1'b1, 1'b0, 16'h5A5A, 1'b1, 1'b0, 16'hA5A5);
    chk("post_rst_fwft", 32'(b1.data_out), 32'hA5A5);
    step(1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 16'h0);
    chk("post_rst_dout", 32'(b0.data_out), 32'h5A5A);
    chk("post_rst_empty", 32'(b0.empty), 32'd1);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
